// File: rtl/rtl_settings_pkg.sv
// Shared types and helpers for the AMM read-data checker path.
package rtl_settings_pkg;

  localparam int unsigned RD_ADDR_W  = 32;
  localparam int unsigned RD_DATA_W  = 128;
  localparam int unsigned RD_BURST_W = 11;
  localparam int unsigned DATA_B_W   = RD_DATA_W / 8;
  localparam int unsigned ADDR_B_W   = $clog2(DATA_B_W);

  typedef enum logic {
    FIXED_DATA = 1'b0,
    RND_DATA   = 1'b1
  } data_mode_t;

  typedef struct packed {
    logic [RD_ADDR_W-ADDR_B_W-1:0] start_addr;
    logic [ADDR_B_W-1:0]           start_off;
    logic [ADDR_B_W-1:0]           end_off;
    logic [RD_BURST_W-2:0]         words_count;
    data_mode_t                    data_mode;
    logic [7:0]                    data_ptrn;
  } rd_desc_t;

  // Next pattern byte for RND mode (shift left, feedback taps 7,5,4,3).
  function automatic logic [7:0] lfsr8_next(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// Synchronous show-ahead FIFO holding queued read descriptors.
module desc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (rd && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write.
  always_ff @(posedge clk_i) begin
    if (wr && !full) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/receiver_block.sv
// Read-data checker: queues expected-read descriptors, regenerates the byte
// pattern per beat, compares enabled bytes and reports the first mismatch.
module receiver_block
  import rtl_settings_pkg::*;
#(
  parameter int unsigned ADDR_W          = RD_ADDR_W,
  parameter int unsigned AMM_DATA_W      = RD_DATA_W,
  parameter int unsigned AMM_BURST_W     = RD_BURST_W,
  parameter int unsigned DESC_FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  rd_desc_t              desc_i,
  input  logic                  readdatavalid_i,
  input  logic [AMM_DATA_W-1:0] readdata_i,
  input  logic                  err_clr_i,
  output logic                  rd_busy_o,
  output logic                  cmp_error_o,
  output logic                  unexp_data_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  output logic [7:0]            err_data_o,
  output logic [7:0]            err_exp_o,
  output logic [31:0]           words_rcvd_o
);

  localparam int unsigned WA_W = ADDR_W - ADDR_B_W;
  localparam logic [WA_W-1:0]          WA_ONE = 1;
  localparam logic [AMM_BURST_W-2:0]   BC_ONE = 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [$bits(rd_desc_t)-1:0] head_bits;
  rd_desc_t               head;
  logic                   fifo_full, fifo_empty, fifo_rd;

  logic [WA_W-1:0]        word_addr;
  logic [ADDR_B_W-1:0]    s_off, e_off;
  logic [AMM_BURST_W-2:0] beat_cnt;
  logic                   first_beat;
  data_mode_t             mode;
  logic [7:0]             cur_ptrn;

  logic                   active_beat, last_beat;
  logic [DATA_B_W-1:0]    byte_mask, mism;
  logic                   hit;
  logic [ADDR_B_W-1:0]    hit_idx;
  logic [7:0]             hit_byte;

  assign head         = rd_desc_t'(head_bits);
  assign desc_ready_o = !fifo_full;
  assign rd_busy_o    = (state == ACTIVE) || !fifo_empty;
  assign active_beat  = (state == ACTIVE) && readdatavalid_i;
  assign last_beat    = (beat_cnt == '0);
  // Next head is loaded from IDLE, or on the last beat so bursts run back-to-back.
  assign fifo_rd      = !fifo_empty && ((state == IDLE) || (active_beat && last_beat));

  desc_fifo #(
    .WIDTH ($bits(rd_desc_t)),
    .DEPTH (DESC_FIFO_DEPTH)
  ) u_desc_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr      (desc_valid_i && !fifo_full),
    .wr_data (desc_i),
    .rd      (fifo_rd),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Byte-enable mask, per-byte compare and lowest-index mismatch pick.
  always_comb begin
    byte_mask = '0;
    mism      = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    hit_byte  = '0;
    for (int unsigned i = 0; i < DATA_B_W; i++) begin
      byte_mask[i] = (!first_beat || (i >= 32'(s_off))) &&
                     (!last_beat  || (i <= 32'(e_off)));
      mism[i] = active_beat && byte_mask[i] && (readdata_i[8*i +: 8] != cur_ptrn);
      if (mism[i] && !hit) begin
        hit      = 1'b1;
        hit_idx  = ADDR_B_W'(i);
        hit_byte = readdata_i[8*i +: 8];
      end
    end
  end

  // Burst tracking FSM: descriptor load, beat countdown, address and pattern advance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      word_addr  <= '0;
      s_off      <= '0;
      e_off      <= '0;
      beat_cnt   <= '0;
      first_beat <= 1'b0;
      mode       <= FIXED_DATA;
      cur_ptrn   <= '0;
    end else if (fifo_rd) begin
      state      <= ACTIVE;
      word_addr  <= head.start_addr;
      s_off      <= head.start_off;
      e_off      <= head.end_off;
      beat_cnt   <= head.words_count;
      first_beat <= 1'b1;
      mode       <= head.data_mode;
      cur_ptrn   <= head.data_ptrn;
    end else if (active_beat && last_beat) begin
      state <= IDLE;
    end else if (active_beat) begin
      beat_cnt   <= beat_cnt - BC_ONE;
      word_addr  <= word_addr + WA_ONE;
      first_beat <= 1'b0;
      if (mode == RND_DATA) cur_ptrn <= lfsr8_next(cur_ptrn);
    end
  end

  // Sticky flags, first-error capture and beat statistics.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_error_o  <= 1'b0;
      unexp_data_o <= 1'b0;
      err_addr_o   <= '0;
      err_data_o   <= '0;
      err_exp_o    <= '0;
      words_rcvd_o <= '0;
    end else begin
      if (readdatavalid_i) words_rcvd_o <= words_rcvd_o + 32'd1;
      unexp_data_o <= (readdatavalid_i && (state == IDLE)) || (unexp_data_o && !err_clr_i);
      // A mismatch coincident with a clear re-arms the capture instead of being lost.
      if (hit && (!cmp_error_o || err_clr_i)) begin
        cmp_error_o <= 1'b1;
        err_addr_o  <= {word_addr, hit_idx};
        err_data_o  <= hit_byte;
        err_exp_o   <= cur_ptrn;
      end else if (err_clr_i) begin
        cmp_error_o <= 1'b0;
        err_addr_o  <= '0;
        err_data_o  <= '0;
        err_exp_o   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_receiver_block.sv
// Scoreboard bench for receiver_block: each beat pushes the expected status,
// a monitor pops and compares one cycle after the beat is taken.
module tb_receiver_block;
  import rtl_settings_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           desc_valid;
  logic           desc_ready;
  rd_desc_t       desc;
  logic           readdatavalid;
  logic [127:0]   readdata;
  logic           err_clr;
  logic           rd_busy;
  logic           cmp_error;
  logic           unexp_data;
  logic [31:0]    err_addr;
  logic [7:0]     err_data;
  logic [7:0]     err_exp;
  logic [31:0]    words_rcvd;

  always #5 clk = ~clk;

  receiver_block #(
    .ADDR_W          (32),
    .AMM_DATA_W      (128),
    .AMM_BURST_W     (11),
    .DESC_FIFO_DEPTH (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .desc_valid_i    (desc_valid),
    .desc_ready_o    (desc_ready),
    .desc_i          (desc),
    .readdatavalid_i (readdatavalid),
    .readdata_i      (readdata),
    .err_clr_i       (err_clr),
    .rd_busy_o       (rd_busy),
    .cmp_error_o     (cmp_error),
    .unexp_data_o    (unexp_data),
    .err_addr_o      (err_addr),
    .err_data_o      (err_data),
    .err_exp_o       (err_exp),
    .words_rcvd_o    (words_rcvd)
  );

  typedef struct {
    logic        cmp;
    logic        unexp;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
    logic [31:0] words;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  exp_t        mon_x;
  int unsigned exp_words = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted beat yields one status snapshot to compare.
  always @(posedge clk) begin
    if (readdatavalid && !rst) begin
      #1;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got beat with empty queue at %0t", $time);
      end else begin
        mon_x = sb.pop_front();
        chk("cmp_error",  {31'd0, cmp_error},  {31'd0, mon_x.cmp});
        chk("unexp_data", {31'd0, unexp_data}, {31'd0, mon_x.unexp});
        chk("err_addr",   err_addr,            mon_x.addr);
        chk("err_data",   {24'd0, err_data},   {24'd0, mon_x.data});
        chk("err_exp",    {24'd0, err_exp},    {24'd0, mon_x.exp});
        chk("words_rcvd", words_rcvd,          mon_x.words);
      end
    end
  end

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [127:0] set_byte(input logic [127:0] d, input int idx, input logic [7:0] b);
    logic [127:0] r;
    r = d;
    r[8*idx +: 8] = b;
    return r;
  endfunction

  task automatic clear_exp();
    e.cmp   = 1'b0;
    e.unexp = 1'b0;
    e.addr  = '0;
    e.data  = '0;
    e.exp   = '0;
  endtask

  task automatic send_desc(input logic [27:0] a, input logic [3:0] so, input logic [3:0] eo,
                           input logic [9:0] wc, input data_mode_t m, input logic [7:0] p);
    int t;
    @(negedge clk);
    readdatavalid = 1'b0;
    err_clr       = 1'b0;
    desc_valid    = 1'b1;
    desc.start_addr  = a;
    desc.start_off   = so;
    desc.end_off     = eo;
    desc.words_count = wc;
    desc.data_mode   = m;
    desc.data_ptrn   = p;
    t = 0;
    while (!desc_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL desc_timeout: got desc_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d, input logic clr = 1'b0);
    @(negedge clk);
    readdatavalid = 1'b1;
    readdata      = d;
    err_clr       = clr;
    exp_words++;
    e.words = exp_words;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    readdatavalid = 1'b0;
    err_clr       = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    readdatavalid = 1'b0;
    err_clr       = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    clear_exp();
    chk("clr_cmp_error",  {31'd0, cmp_error},  32'd0);
    chk("clr_unexp_data", {31'd0, unexp_data}, 32'd0);
    chk("clr_err_addr",   err_addr,            32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmp_error"},  {31'd0, cmp_error},  32'd0);
    chk({tag, "_unexp"},      {31'd0, unexp_data}, 32'd0);
    chk({tag, "_err_addr"},   err_addr,            32'd0);
    chk({tag, "_err_data"},   {24'd0, err_data},   32'd0);
    chk({tag, "_err_exp"},    {24'd0, err_exp},    32'd0);
    chk({tag, "_words"},      words_rcvd,          32'd0);
    chk({tag, "_desc_ready"}, {31'd0, desc_ready}, 32'd1);
    chk({tag, "_rd_busy"},    {31'd0, rd_busy},    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    rst = 1'b1;
    desc_valid = 1'b0;
    desc = '0;
    readdatavalid = 1'b0;
    readdata = '0;
    err_clr = 1'b0;
    clear_exp();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // 1: FIXED 0xA5, four full beats, no error
    send_desc(28'h100, 4'd0, 4'd15, 10'd3, FIXED_DATA, 8'hA5);
    repeat (4) beat(fill(8'hA5));
    idle();

    // 2: RND 0xFF -> 0xFE, then corrupted byte 3 on beat 2
    send_desc(28'h200, 4'd0, 4'd15, 10'd1, RND_DATA, 8'hFF);
    beat(fill(8'hFF));
    beat(fill(8'hFE));
    idle();
    send_desc(28'h200, 4'd0, 4'd15, 10'd1, RND_DATA, 8'hFF);
    beat(fill(8'hFF));
    e.cmp = 1'b1; e.addr = 32'h2013; e.data = 8'h00; e.exp = 8'hFE;
    beat(set_byte(fill(8'hFE), 3, 8'h00));
    idle();
    clear_err();

    // 3: single beat, bytes 4..9 only
    d = '0;
    for (int i = 4; i <= 9; i++) d = set_byte(d, i, 8'h3C);
    send_desc(28'h300, 4'd4, 4'd9, 10'd0, FIXED_DATA, 8'h3C);
    beat(set_byte(set_byte(d, 3, 8'h11), 10, 8'h22));
    idle();
    send_desc(28'h300, 4'd4, 4'd9, 10'd0, FIXED_DATA, 8'h3C);
    e.cmp = 1'b1; e.addr = 32'h3009; e.data = 8'h3D; e.exp = 8'h3C;
    beat(set_byte(d, 9, 8'h3D));
    idle();
    clear_err();

    // 4: one active plus four queued descriptors, back-to-back bursts
    send_desc(28'h400, 4'd0, 4'd15, 10'd1, FIXED_DATA, 8'h10);
    send_desc(28'h410, 4'd0, 4'd15, 10'd1, FIXED_DATA, 8'h11);
    send_desc(28'h420, 4'd0, 4'd15, 10'd1, RND_DATA,   8'h01);
    send_desc(28'h430, 4'd0, 4'd15, 10'd1, FIXED_DATA, 8'h13);
    send_desc(28'h440, 4'd0, 4'd15, 10'd1, FIXED_DATA, 8'h14);
    chk("full_desc_ready", {31'd0, desc_ready}, 32'd0);
    chk("full_rd_busy",    {31'd0, rd_busy},    32'd1);
    beat(fill(8'h10)); beat(fill(8'h10));
    beat(fill(8'h11)); beat(fill(8'h11));
    beat(fill(8'h01)); beat(fill(8'h02));
    beat(fill(8'h13)); beat(fill(8'h13));
    beat(fill(8'h14)); beat(fill(8'h14));
    idle();
    chk("drain_rd_busy",    {31'd0, rd_busy},    32'd0);
    chk("drain_desc_ready", {31'd0, desc_ready}, 32'd1);

    // 5: unexpected beat, then clear coincident with a new mismatch
    e.unexp = 1'b1;
    beat(fill(8'h00));
    idle();
    send_desc(28'h500, 4'd0, 4'd15, 10'd0, FIXED_DATA, 8'h55);
    e.cmp = 1'b1; e.addr = 32'h5002; e.data = 8'h00; e.exp = 8'h55;
    beat(set_byte(fill(8'h55), 2, 8'h00));
    idle();
    send_desc(28'h510, 4'd0, 4'd15, 10'd0, FIXED_DATA, 8'h55);
    e.cmp = 1'b1; e.unexp = 1'b0; e.addr = 32'h5105; e.data = 8'h77; e.exp = 8'h55;
    beat(set_byte(fill(8'h55), 5, 8'h77), 1'b1);
    idle();
    clear_err();

    // 6: reset mid-burst with a descriptor still queued
    send_desc(28'h600, 4'd0, 4'd15, 10'd3, FIXED_DATA, 8'h66);
    send_desc(28'h610, 4'd0, 4'd15, 10'd0, FIXED_DATA, 8'h99);
    beat(fill(8'h66));
    beat(fill(8'h66));
    @(negedge clk);
    readdatavalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_words = 0;
    clear_exp();
    check_idle_outputs("midrst");
    e.unexp = 1'b1;
    beat(fill(8'h66));
    idle();
    clear_err();
    send_desc(28'h700, 4'd0, 4'd15, 10'd0, FIXED_DATA, 8'h77);
    e.cmp = 1'b1; e.addr = 32'h7000; e.data = 8'h00; e.exp = 8'h77;
    beat(set_byte(fill(8'h77), 0, 8'h00));
    idle();

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
